// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the combinational instruction ROM between IF and MEM with bounded IF starvation.
module rom_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH_LOG2   = 17,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_stall,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]        starve_cnt;
    logic              force_if;
    logic              mem_gnt;
    logic              if_gnt;
    logic              if_fire;
    logic              ok;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] rsp_data;
    // Grants are suppressed while reset is held so the ROM stays idle.
    always_comb begin
        force_if  = if_req && mem_req && starve_cnt == LIMIT;
        mem_gnt   = rst && mem_req && !force_if;
        if_gnt    = rst && if_req && !mem_gnt;
        if_fire   = if_gnt && !if_flush;
        gnt_addr  = mem_gnt ? mem_addr : if_addr;
        ok        = gnt_addr[1:0] == 2'b00 && (gnt_addr >> (DEPTH_LOG2 + 2)) == '0;
        rom_ce    = (if_gnt || mem_gnt) && ok;
        rom_addr  = (if_gnt || mem_gnt) ? gnt_addr : '0;
        rsp_data  = ok ? rom_inst : '0;
        if_stall  = if_req && !if_gnt;
        mem_stall = mem_req && !mem_gnt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_err    <= 1'b0;
        end else begin
            starve_cnt <= (!if_req || if_gnt) ? 4'd0 :
                          (mem_gnt && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
            if_rvalid  <= if_fire;
            mem_rvalid <= mem_gnt;
            if (if_fire) begin
                if_rdata <= rsp_data;
                if_err   <= !ok;
            end
            if (mem_gnt) begin
                mem_rdata <= rsp_data;
                mem_err   <= !ok;
            end
        end
    end
endmodule
